cod_bebida: RTL and testbench

COD_BEBIDA -- requirements
Module: cod_bebida

---
 rtl/cod_bebida.sv | 170 +++++++++++++++++
 tb/tb_cod_bebida.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cod_bebida.sv
// cod_bebida: drink-selection controller.
// Button edges drive an IDLE -> SELECT -> DISPENSE cycle. Outputs are registered
// and reflect a press on the same clock edge that samples it.
module cod_bebida #(
    parameter int unsigned SEL_TIMEOUT = 50000000,
    parameter int unsigned DISP_MAX    = 500000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_next,
    input  logic btn_ok,
    input  logic btn_cancel,
    input  logic done,
    output logic B,
    output logic E,
    output logic F,
    output logic Y,
    output logic start,
    output logic busy,
    output logic err
);

    localparam int unsigned SEL_W  = (SEL_TIMEOUT > 1) ? $clog2(SEL_TIMEOUT) : 1;
    localparam int unsigned DISP_W = (DISP_MAX > 1) ? $clog2(DISP_MAX) : 1;

    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(SEL_TIMEOUT - 1);
    localparam logic [SEL_W-1:0]  SEL_ONE   = SEL_W'(1);
    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_MAX - 1);
    localparam logic [DISP_W-1:0] DISP_ONE  = DISP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SELECT   = 2'd1,
        S_DISPENSE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_prev_next;
    logic               r_prev_ok;
    logic               r_prev_cancel;
    logic               w_edge_next;
    logic               w_edge_ok;
    logic               w_edge_cancel;

    logic [SEL_W-1:0]   r_sel_cnt;
    logic [SEL_W-1:0]   w_sel_cnt_nxt;
    logic [DISP_W-1:0]  r_disp_cnt;
    logic [DISP_W-1:0]  w_disp_cnt_nxt;

    logic [1:0]         r_code;
    logic [1:0]         w_code_nxt;
    logic               r_active;
    logic               w_active_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_start;
    logic               w_start_nxt;
    logic               r_err;
    logic               w_err_nxt;

    // A press is a 0->1 transition against the previously registered sample.
    assign w_edge_next   = btn_next   & ~r_prev_next;
    assign w_edge_ok     = btn_ok     & ~r_prev_ok;
    assign w_edge_cancel = btn_cancel & ~r_prev_cancel;

    // Previous-sample registers; preset to 1 so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_next   <= 1'b1;
            r_prev_ok     <= 1'b1;
            r_prev_cancel <= 1'b1;
        end else begin
            r_prev_next   <= btn_next;
            r_prev_ok     <= btn_ok;
            r_prev_cancel <= btn_cancel;
        end
    end

    // Next state, counters and next output values for the three-state controller.
    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_sel_cnt_nxt  = '0;
        w_disp_cnt_nxt = '0;
        w_start_nxt    = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_code_nxt = '0;
                if (w_edge_next) begin
                    w_state_nxt = S_SELECT;
                end
            end

            S_SELECT: begin
                if (w_edge_cancel) begin
                    w_state_nxt = S_IDLE;
                    w_code_nxt  = '0;
                end else if (w_edge_ok) begin
                    w_state_nxt = S_DISPENSE;
                    w_start_nxt = 1'b1;
                end else if (w_edge_next) begin
                    w_code_nxt  = r_code + 2'd1;
                end else if (r_sel_cnt == SEL_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_code_nxt  = '0;
                end else begin
                    w_sel_cnt_nxt = r_sel_cnt + SEL_ONE;
                end
            end

            S_DISPENSE: begin
                // r_start marks the first DISPENSE cycle, during which done is ignored.
                if (done && !r_start) begin
                    w_state_nxt = S_IDLE;
                    w_code_nxt  = '0;
                end else if (r_disp_cnt == DISP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_code_nxt  = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_disp_cnt_nxt = r_disp_cnt + DISP_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_code_nxt  = '0;
            end
        endcase

        w_active_nxt = (w_state_nxt != S_IDLE);
        w_busy_nxt   = (w_state_nxt == S_DISPENSE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sel_cnt  <= '0;
            r_disp_cnt <= '0;
            r_code     <= '0;
            r_active   <= 1'b0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel_cnt  <= w_sel_cnt_nxt;
            r_disp_cnt <= w_disp_cnt_nxt;
            r_code     <= w_code_nxt;
            r_active   <= w_active_nxt;
            r_busy     <= w_busy_nxt;
            r_start    <= w_start_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign B     = r_active;
    assign Y     = r_active;
    assign E     = r_code[1];
    assign F     = r_code[0];
    assign start = r_start;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule

// File: tb/tb_cod_bebida.sv
// Self-checking bench for cod_bebida: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the controller.
module tb_cod_bebida;

    localparam int ST = 8;
    localparam int DM = 16;

    logic clk = 1'b0;
    logic reset, btn_next, btn_ok, btn_cancel, done;
    logic B, E, F, Y, start, busy, err;

    cod_bebida #(.SEL_TIMEOUT(ST), .DISP_MAX(DM)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_next   (btn_next),
        .btn_ok     (btn_ok),
        .btn_cancel (btn_cancel),
        .done       (done),
        .B          (B),
        .E          (E),
        .F          (F),
        .Y          (Y),
        .start      (start),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: mode 0 = waiting, 1 = choosing, 2 = pouring.
    int m_mode  = 0;
    int m_code  = 0;
    int m_quiet = 0;   // edges spent choosing without an accepted press
    int m_age   = 0;   // edges spent pouring
    bit m_pn = 1'b1, m_po = 1'b1, m_pc = 1'b1;
    bit m_start = 1'b0, m_err = 1'b0;

    task automatic model_step(input bit r, input bit n, input bit o, input bit c, input bit d);
        bit en, eo, ec;
        if (r) begin
            m_mode = 0; m_code = 0; m_quiet = 0; m_age = 0;
            m_pn = 1'b1; m_po = 1'b1; m_pc = 1'b1;
            m_start = 1'b0; m_err = 1'b0;
            return;
        end
        en = n && !m_pn;
        eo = o && !m_po;
        ec = c && !m_pc;
        m_pn = n; m_po = o; m_pc = c;
        m_start = 1'b0;
        m_err   = 1'b0;
        case (m_mode)
            0: if (en) begin m_mode = 1; m_code = 0; m_quiet = 0; end
            1: begin
                if (ec) begin
                    m_mode = 0; m_code = 0;
                end else if (eo) begin
                    m_mode = 2; m_age = 0; m_start = 1'b1;
                end else if (en) begin
                    m_code = (m_code + 1) % 4; m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet == ST) begin m_mode = 0; m_code = 0; end
                end
            end
            default: begin
                m_age++;
                if (d && m_age > 1) begin
                    m_mode = 0; m_code = 0;
                end else if (m_age == DM) begin
                    m_mode = 0; m_code = 0; m_err = 1'b1;
                end
            end
        endcase
    endtask

    function automatic logic [6:0] model_out();
        logic [1:0] cd;
        cd = 2'(m_code);
        return {m_mode != 0, cd[1], cd[0], m_mode != 0, m_start, m_mode == 2, m_err};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {B, E, F, Y, start, busy, err};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed {B,E,F,Y,start,busy,err}=%b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic cycle(input string tag, input bit r, input bit n, input bit o,
                         input bit c, input bit d);
        reset = r; btn_next = n; btn_ok = o; btn_cancel = c; done = d;
        @(posedge clk);
        model_step(r, n, o, c, d);
        #1;
        check(tag, model_out());
    endtask

    initial begin
        logic [1:0] code;
        reset = 1'b1; btn_next = 1'b0; btn_ok = 1'b0; btn_cancel = 1'b0; done = 1'b0;

        // Reset state
        cycle("reset", 1, 0, 0, 0, 0);
        cycle("reset", 1, 0, 0, 0, 0);
        check("reset_lit", 7'b0000000);
        cycle("idle", 0, 0, 0, 0, 0);
        cycle("idle_ok_ignored", 0, 0, 1, 0, 0);
        cycle("idle_cancel_ignored", 0, 0, 0, 1, 0);
        check("idle_lit", 7'b0000000);

        // Five next presses walk the code 00,01,10,11,00
        for (int i = 0; i < 5; i++) begin
            cycle("next_pulse", 0, 1, 0, 0, 0);
            code = 2'(i % 4);
            check("next_code_lit", {1'b1, code[1], code[0], 1'b1, 3'b000});
            cycle("next_gap", 0, 0, 0, 0, 0);
        end

        // Go to code 10, confirm, done three cycles later
        cycle("to01", 0, 1, 0, 0, 0);
        cycle("gap", 0, 0, 0, 0, 0);
        cycle("to10", 0, 1, 0, 0, 0);
        cycle("gap", 0, 0, 0, 0, 0);
        cycle("ok", 0, 0, 1, 0, 0);
        check("start_lit", 7'b1101110);
        cycle("disp", 0, 0, 0, 0, 0);
        check("busy_lit", 7'b1101010);
        cycle("disp", 0, 0, 0, 0, 0);
        cycle("done", 0, 0, 0, 0, 1);
        check("done_idle_lit", 7'b0000000);

        // ok and cancel together: cancel wins
        cycle("next", 0, 1, 0, 0, 0);
        cycle("ok_cancel", 0, 0, 1, 1, 0);
        check("ok_cancel_lit", 7'b0000000);
        cycle("gap", 0, 0, 0, 0, 0);

        // Inactivity timeout in SELECT
        cycle("next", 0, 1, 0, 0, 0);
        for (int i = 0; i < ST - 1; i++) cycle("sel_wait", 0, 0, 0, 0, 0);
        check("sel_wait_lit", 7'b1001000);
        cycle("sel_timeout", 0, 0, 0, 0, 0);
        check("sel_timeout_lit", 7'b0000000);

        // Dispense timeout with cancel presses ignored
        cycle("next", 0, 1, 0, 0, 0);
        cycle("gap", 0, 0, 0, 0, 0);
        cycle("ok", 0, 0, 1, 0, 0);
        for (int i = 0; i < DM - 1; i++) cycle("disp_cancel", 0, 0, 0, i % 2 == 0, 0);
        check("disp_hold_lit", 7'b1001010);
        cycle("disp_timeout", 0, 0, 0, 0, 0);
        check("err_lit", 7'b0000001);
        cycle("after_err", 0, 0, 0, 0, 0);
        check("after_err_lit", 7'b0000000);

        // done during start cycle ignored; done coinciding with timeout wins
        cycle("next", 0, 1, 0, 0, 0);
        cycle("gap", 0, 0, 0, 0, 0);
        cycle("ok", 0, 0, 1, 0, 1);
        cycle("done_in_start", 0, 0, 0, 0, 1);
        check("done_in_start_lit", 7'b1001010);
        for (int i = 0; i < DM - 2; i++) cycle("disp", 0, 0, 0, 0, 0);
        cycle("done_at_limit", 0, 0, 0, 0, 1);
        check("done_beats_err_lit", 7'b0000000);

        // Button held through reset release
        cycle("reset_held", 1, 1, 0, 0, 0);
        cycle("reset_held", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("held_after_reset", 0, 1, 0, 0, 0);
        check("held_lit", 7'b0000000);
        cycle("release", 0, 0, 0, 0, 0);
        cycle("press", 0, 1, 0, 0, 0);
        check("press_lit", 7'b1001000);

        // Reset mid-dispense
        cycle("gap", 0, 0, 0, 0, 0);
        cycle("ok", 0, 0, 1, 0, 0);
        cycle("disp", 0, 0, 0, 0, 0);
        cycle("reset_mid", 1, 0, 0, 0, 0);
        check("reset_mid_lit", 7'b0000000);

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            cycle("random",
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
